// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART byte receiver with fixed-length multi-channel frame parser.
// Define UART_FRAME_RX_CHK_EN to add a checksum byte between payload and trailer.
module uart_frame_rx #(
  parameter int         CLK_HZ        = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter int         NCH           = 2,
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] HDR_BASE      = 8'hAA,
  parameter int         TIMEOUT_BITS  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            uart_rx,
  output logic [7:0]                      rx_byte,
  output logic                            rx_byte_valid,
  output logic [NCH*8*PAYLOAD_BYTES-1:0]  data,
  output logic [NCH-1:0]                  data_valid,
  output logic                            frame_err
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int W      = 8 * PAYLOAD_BYTES;
  localparam int CW     = $clog2(DIV);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_M1    = TW'(TO_CYC - 1);
  localparam logic [2:0]    LAST_PAY = 3'(PAYLOAD_BYTES - 1);

  function automatic logic [7:0] hdr_of(input logic [2:0] c);
    return HDR_BASE + 8'h22 * {5'd0, c};
  endfunction

  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  logic [2:0] sync;
  logic       rx_line;
  logic       fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b111;
    else        sync <= {sync[1:0], uart_rx};
  end

  assign rx_line = sync[1];
  assign fall    = !sync[1] && sync[2];

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t   rstate;
  logic [CW-1:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        byte_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate        <= R_IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      byte_err      <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      byte_err      <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (fall) begin
            rstate  <= R_START;
            bit_cnt <= '0;
          end
        end
        R_START: begin
          // A line already back high at mid start bit is treated as a glitch
          if (bit_cnt == HALF_M1) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            rstate  <= rx_line ? R_IDLE : R_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            shreg   <= {rx_line, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rstate <= R_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            if (rx_line) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              byte_err <= 1'b1;
              rstate   <= R_WAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_WAIT: begin
          if (rx_line) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

`ifdef UART_FRAME_RX_CHK_EN
  typedef enum logic [1:0] {P_IDLE, P_PAY, P_CHK, P_TRL} p_state_t;
  logic [7:0] sum;
`else
  typedef enum logic [1:0] {P_IDLE, P_PAY, P_TRL} p_state_t;
`endif

  p_state_t      pstate;
  logic [2:0]    ch;
  logic [2:0]    cnt;
  logic [W-1:0]  pay_sr;
  logic [TW-1:0] to_cnt;
  logic          hdr_hit;
  logic [2:0]    hdr_ch;
  logic [7:0]    trl_byte;

  always_comb begin
    hdr_hit = 1'b0;
    hdr_ch  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rx_byte == hdr_of(3'(k))) begin
        hdr_hit = 1'b1;
        hdr_ch  = 3'(k);
      end
    end
  end

  assign trl_byte = hdr_of(ch) + 8'h11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate     <= P_IDLE;
      ch         <= '0;
      cnt        <= '0;
      pay_sr     <= '0;
      to_cnt     <= '0;
      data       <= '0;
      data_valid <= '0;
      frame_err  <= 1'b0;
`ifdef UART_FRAME_RX_CHK_EN
      sum        <= '0;
`endif
    end else begin
      data_valid <= '0;
      // A broken byte aborts any frame in progress; one error pulse covers both
      frame_err  <= byte_err;
      if (byte_err) pstate <= P_IDLE;

      if (pstate == P_IDLE || rx_byte_valid) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_M1) begin
        to_cnt    <= '0;
        pstate    <= P_IDLE;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (rx_byte_valid) begin
        case (pstate)
          P_IDLE: begin
            if (hdr_hit) begin
              ch     <= hdr_ch;
              pay_sr <= '0;
              cnt    <= '0;
              pstate <= P_PAY;
`ifdef UART_FRAME_RX_CHK_EN
              sum    <= rx_byte;
`endif
            end
          end
          P_PAY: begin
            pay_sr <= W'({pay_sr, rx_byte});
`ifdef UART_FRAME_RX_CHK_EN
            sum    <= sum + rx_byte;
`endif
            if (cnt == LAST_PAY) begin
`ifdef UART_FRAME_RX_CHK_EN
              pstate <= P_CHK;
`else
              pstate <= P_TRL;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_FRAME_RX_CHK_EN
          P_CHK: begin
            if (rx_byte == sum) begin
              pstate <= P_TRL;
            end else begin
              frame_err <= 1'b1;
              pstate    <= P_IDLE;
            end
          end
`endif
          P_TRL: begin
            if (rx_byte == trl_byte) begin
              for (int k = 0; k < NCH; k++) begin
                if (ch == 3'(k)) begin
                  data[k*W +: W] <= pay_sr;
                  data_valid[k]  <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
            pstate <= P_IDLE;
          end
          default: pstate <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx (DIV = 16, two channels, 4-byte payload).
module tb_uart_frame_rx;

  localparam int DIV    = 16;
  localparam int NCH    = 2;
  localparam int W      = 32;
  localparam int TO_CYC = 32 * DIV;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 uart_rx;
  logic [7:0]           rx_byte;
  logic                 rx_byte_valid;
  logic [NCH*W-1:0]     data;
  logic [NCH-1:0]       data_valid;
  logic                 frame_err;

  uart_frame_rx #(
    .CLK_HZ(1_600_000),
    .BAUD(100_000),
    .NCH(NCH),
    .PAYLOAD_BYTES(4),
    .HDR_BASE(8'hAA),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .data(data),
    .data_valid(data_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   dv;
    logic             err;
    logic [NCH*W-1:0] data;
    int               gap_lo;
    int               gap_hi;
  } evt_t;

  evt_t       evt_q[$];
  logic [7:0] byte_q[$];
  logic [W-1:0] exp_data [NCH];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rbv = -1000000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] pack();
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = exp_data[k];
    return r;
  endfunction

  task automatic push_ok(input int c, input logic [W-1:0] v);
    evt_t e;
    exp_data[c] = v;
    e.dv = NCH'(1) << c;
    e.err = 1'b0;
    e.data = pack();
    e.gap_lo = 1;
    e.gap_hi = 1;
    evt_q.push_back(e);
  endtask

  task automatic push_err(input int lo, input int hi);
    evt_t e;
    e.dv = '0;
    e.err = 1'b1;
    e.data = pack();
    e.gap_lo = lo;
    e.gap_hi = hi;
    evt_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT strobes an output
  initial begin
    evt_t e;
    logic [7:0] eb;
    int gap;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (rx_byte_valid) begin
          if (byte_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_byte: got %h expected none", rx_byte);
          end else begin
            eb = byte_q.pop_front();
            check("rx_byte", 64'(rx_byte), 64'(eb));
          end
        end
        if (data_valid != '0 || frame_err) begin
          if (evt_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got data_valid=%b frame_err=%b expected none", data_valid, frame_err);
          end else begin
            e = evt_q.pop_front();
            check("data_valid", 64'(data_valid), 64'(e.dv));
            check("frame_err", 64'(frame_err), 64'(e.err));
            check("data", 64'(data), 64'(e.data));
            if (e.gap_lo >= 0) begin
              gap = cyc - last_rbv;
              checks++;
              if (gap < e.gap_lo || gap > e.gap_hi) begin
                failures++;
                $display("FAIL event_latency: got %0d cycles expected %0d..%0d", gap, e.gap_lo, e.gap_hi);
              end
            end
          end
        end
        if (rx_byte_valid) last_rbv = cyc;
      end
    end
  end

  task automatic bit_time();
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      bit_time();
    end
    uart_rx = stop_bit;
    bit_time();
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_q.push_back(b);
    send_raw(b, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [W-1:0] pay, input logic [7:0] trl);
    logic [7:0] s;
    s = hdr;
    send_byte(hdr);
    for (int i = 0; i < 4; i++) begin
      send_byte(pay[31-8*i -: 8]);
      s = s + pay[31-8*i -: 8];
    end
`ifdef UART_FRAME_RX_CHK_EN
    send_byte(s);
`endif
    send_byte(trl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    for (int k = 0; k < NCH; k++) exp_data[k] = '0;
    repeat (5) @(negedge clk);
    check("reset_rx_byte", 64'(rx_byte), 64'h0);
    check("reset_rx_byte_valid", 64'(rx_byte_valid), 64'h0);
    check("reset_data", 64'(data), 64'h0);
    check("reset_data_valid", 64'(data_valid), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push_ok(0, 32'h12345678);
    send_frame(8'hAA, 32'h12345678, 8'hBB);
    push_ok(1, 32'h00BB0001);
    send_frame(8'hCC, 32'h00BB0001, 8'hDD);
    push_err(1, 1);
    send_frame(8'hAA, 32'h01020304, 8'hEE);
    push_ok(0, 32'h11223344);
    send_frame(8'hAA, 32'h11223344, 8'hBB);

    push_err(TO_CYC, TO_CYC + 2);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (40) bit_time();
    send_byte(8'h42);
    push_ok(1, 32'h55667788);
    send_frame(8'hCC, 32'h55667788, 8'hDD);

    push_err(-1, -1);
    send_raw(8'h5A, 1'b0);
    repeat (3) bit_time();

    uart_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) bit_time();

`ifdef UART_FRAME_RX_CHK_EN
    push_ok(0, 32'h01020304);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'hB4); send_byte(8'hBB);
    push_err(1, 1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'hB5); send_byte(8'hBB);
    repeat (2) bit_time();
`endif

    send_byte(8'hAA);
    send_byte(8'h01);
    uart_rx = 1'b0;
    repeat (DIV * 3) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_data", 64'(data), 64'h0);
    check("midreset_rx_byte", 64'(rx_byte), 64'h0);
    check("midreset_frame_err", 64'(frame_err), 64'h0);
    for (int k = 0; k < NCH; k++) exp_data[k] = '0;
    rst_n = 1'b1;
    repeat (2) bit_time();
    push_ok(0, 32'h99887766);
    send_frame(8'hAA, 32'h99887766, 8'hBB);

    for (int i = 0; i < 4000 && (byte_q.size() != 0 || evt_q.size() != 0); i++) @(negedge clk);
    check("byte_q_drained", 64'(byte_q.size()), 64'h0);
    check("evt_q_drained", 64'(evt_q.size()), 64'h0);
    repeat (50) @(negedge clk);
    check("data_hold", 64'(data), 64'(pack()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
